controlador_movimento_porta: RTL and testbench

Elevator motion and door sequencer. It sits directly downstream of the request memory/next-floor selector and consumes that stage's proximo_andar and leitura_endereco outputs. It produces andar_atual, movimento_elevador, indicador_porta_aberta and porta_fechada, which feed back into the memory stage and close the control loop. Floor travel time and door dwell time are timed with internal counters.

---
 rtl/controlador_movimento_porta.sv | 116 +++++++++++
 tb/tb_controlador_movimento_porta.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_movimento_porta.sv
// Elevator motion and door sequencer.
// Takes the selected target floor and the "request at this floor" flag from the
// request memory stage. It drives the car one floor at a time and runs the
// door dwell timer. Its outputs feed back into the memory stage.
// Every arrival passes through PARADO for one cycle. This lets a request
// raised at an intermediate floor stop the car there.
module controlador_movimento_porta #(
    parameter int CICLOS_ANDAR = 8,   // cycles to travel one floor (>= 2)
    parameter int CICLOS_PORTA = 5    // unobstructed door dwell in cycles (>= 2)
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic [1:0] proximo_andar,
    input  logic       andar_solicitado,
    input  logic       obstrucao_porta,
    output logic [1:0] andar_atual,
    output logic       movimento_elevador,
    output logic       em_movimento,
    output logic       indicador_porta_aberta,
    output logic       porta_fechada
);

    // One counter is shared by the floor timer and the door timer. It is
    // sized for the longer of the two intervals.
    localparam int CICLOS_MAX = (CICLOS_ANDAR > CICLOS_PORTA) ? CICLOS_ANDAR : CICLOS_PORTA;
    localparam int CW         = (CICLOS_MAX > 1) ? $clog2(CICLOS_MAX) : 1;

    localparam logic [CW-1:0] ULT_ANDAR = CW'(CICLOS_ANDAR - 1);
    localparam logic [CW-1:0] ULT_PORTA = CW'(CICLOS_PORTA - 1);

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        MOVENDO = 2'd1,
        ABERTA  = 2'd2
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] contador;

    // Sequencer: state, timers and all outputs are updated together so every
    // output is a flop.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            estado                 <= PARADO;
            contador               <= '0;
            andar_atual            <= 2'd0;
            movimento_elevador     <= 1'b1;
            em_movimento           <= 1'b0;
            indicador_porta_aberta <= 1'b0;
            porta_fechada          <= 1'b1;
        end else begin
            case (estado)
                PARADO: begin
                    contador <= '0;
                    // A request at this floor wins over leaving for another one.
                    if (andar_solicitado) begin
                        estado                 <= ABERTA;
                        indicador_porta_aberta <= 1'b1;
                        porta_fechada          <= 1'b0;
                    end else if (proximo_andar != andar_atual) begin
                        estado             <= MOVENDO;
                        em_movimento       <= 1'b1;
                        movimento_elevador <= (proximo_andar > andar_atual);
                    end
                end

                MOVENDO: begin
                    // Direction stays latched until the next floor is reached.
                    // The target is not looked at again until PARADO.
                    if (contador == ULT_ANDAR) begin
                        contador     <= '0;
                        estado       <= PARADO;
                        em_movimento <= 1'b0;
                        // Saturating step. The boundary cases cannot occur
                        // with a sane target, but they must never wrap.
                        if (movimento_elevador) begin
                            if (andar_atual != 2'd3)
                                andar_atual <= andar_atual + 2'd1;
                        end else begin
                            if (andar_atual != 2'd0)
                                andar_atual <= andar_atual - 2'd1;
                        end
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end

                ABERTA: begin
                    // An obstruction restarts the full dwell.
                    // andar_solicitado is ignored here; the memory stage
                    // clears it while the door is open.
                    if (obstrucao_porta) begin
                        contador <= '0;
                    end else if (contador == ULT_PORTA) begin
                        contador               <= '0;
                        estado                 <= PARADO;
                        indicador_porta_aberta <= 1'b0;
                        porta_fechada          <= 1'b1;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end

                default: begin
                    // The unused encoding falls back to a safe, closed, stationary state.
                    estado                 <= PARADO;
                    contador               <= '0;
                    em_movimento           <= 1'b0;
                    indicador_porta_aberta <= 1'b0;
                    porta_fechada          <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_movimento_porta.sv
// Bench for controlador_movimento_porta with CICLOS_ANDAR=4 and CICLOS_PORTA=3.
// It covers a directed vector table, hand-written reset and intermediate-stop
// sequences, and random traffic checked against a countdown-based model.
module tb_controlador_movimento_porta;

    localparam int CA = 4;
    localparam int CP = 3;

    logic       clock_in = 1'b0;
    logic       reset_n  = 1'b0;
    logic [1:0] proximo_andar = 2'd0;
    logic       andar_solicitado = 1'b0;
    logic       obstrucao_porta  = 1'b0;
    logic [1:0] andar_atual;
    logic       movimento_elevador;
    logic       em_movimento;
    logic       indicador_porta_aberta;
    logic       porta_fechada;

    int n_tests = 0;
    int n_fail  = 0;

    controlador_movimento_porta #(.CICLOS_ANDAR(CA), .CICLOS_PORTA(CP)) dut (
        .clock_in               (clock_in),
        .reset_n                (reset_n),
        .proximo_andar          (proximo_andar),
        .andar_solicitado       (andar_solicitado),
        .obstrucao_porta        (obstrucao_porta),
        .andar_atual            (andar_atual),
        .movimento_elevador     (movimento_elevador),
        .em_movimento           (em_movimento),
        .indicador_porta_aberta (indicador_porta_aberta),
        .porta_fechada          (porta_fechada)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    // Directed vectors: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic [1:0] prox;
        logic       req;
        logic       obs;
        logic [1:0] andar;
        logic       dir;
        logic       mov;
        logic       porta;
    } vec_t;

    vec_t tab[$];

    // The reference model describes behaviour as "cycles left" on the current
    // trip or dwell. An idle car has both at zero.
    int m_andar, m_dir, m_mov_left, m_porta_left;

    task automatic add(input int n, input logic [1:0] prox, input logic req, input logic obs,
                       input logic [1:0] andar, input logic dir, input logic mov, input logic porta);
        vec_t v;
        v.prox = prox; v.req = req; v.obs = obs;
        v.andar = andar; v.dir = dir; v.mov = mov; v.porta = porta;
        for (int k = 0; k < n; k++) tab.push_back(v);
    endtask

    task automatic chk(input string nome, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] a, input logic d,
                            input logic m, input logic p);
        chk({tag, ".andar"},   {6'd0, andar_atual},            {6'd0, a});
        chk({tag, ".dir"},     {7'd0, movimento_elevador},     {7'd0, d});
        chk({tag, ".mov"},     {7'd0, em_movimento},           {7'd0, m});
        chk({tag, ".aberta"},  {7'd0, indicador_porta_aberta}, {7'd0, p});
        chk({tag, ".fechada"}, {7'd0, porta_fechada},          {7'd0, ~p});
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic model_reset();
        m_andar = 0; m_dir = 1; m_mov_left = 0; m_porta_left = 0;
    endtask

    task automatic model_edge(input int prox, input bit req, input bit obs);
        if (m_porta_left > 0) begin
            if (obs) m_porta_left = CP;
            else     m_porta_left = m_porta_left - 1;
        end else if (m_mov_left > 0) begin
            m_mov_left = m_mov_left - 1;
            if (m_mov_left == 0) begin
                if (m_dir == 1) m_andar = (m_andar < 3) ? m_andar + 1 : 3;
                else            m_andar = (m_andar > 0) ? m_andar - 1 : 0;
            end
        end else if (req) begin
            m_porta_left = CP;
        end else if (prox != m_andar) begin
            m_dir      = (prox > m_andar) ? 1 : 0;
            m_mov_left = CA;
        end
    endtask

    initial begin
        // ---- travel 0->2 ----
        add(4, 2'd2, 0, 0, 2'd0, 1, 1, 0);   // edges 1..4 moving
        add(1, 2'd2, 0, 0, 2'd1, 1, 0, 0);   // edge 5 floor 1, stop
        add(4, 2'd2, 0, 0, 2'd1, 1, 1, 0);   // edges 6..9
        add(3, 2'd2, 0, 0, 2'd2, 1, 0, 0);   // edge 10 arrives, stays
        // ---- door open at floor 2 ----
        add(1, 2'd2, 1, 0, 2'd2, 1, 0, 1);
        add(2, 2'd2, 0, 0, 2'd2, 1, 0, 1);
        add(1, 2'd2, 0, 0, 2'd2, 1, 0, 0);   // closed 3 edges after opening
        // ---- obstruction for 6 cycles ----
        add(1, 2'd2, 1, 0, 2'd2, 1, 0, 1);
        add(6, 2'd2, 0, 1, 2'd2, 1, 0, 1);
        add(2, 2'd2, 0, 0, 2'd2, 1, 0, 1);
        add(1, 2'd2, 0, 0, 2'd2, 1, 0, 0);   // closes 3rd edge after release
        // ---- priority: request together with a new target ----
        add(1, 2'd3, 1, 0, 2'd2, 1, 0, 1);
        add(2, 2'd3, 0, 0, 2'd2, 1, 0, 1);
        add(1, 2'd3, 0, 0, 2'd2, 1, 0, 0);
        add(1, 2'd3, 0, 0, 2'd2, 1, 1, 0);   // now leaves upward
        // ---- frozen direction: target drops below while moving ----
        add(3, 2'd0, 0, 0, 2'd2, 1, 1, 0);
        add(1, 2'd0, 0, 0, 2'd3, 1, 0, 0);
        add(4, 2'd0, 0, 0, 2'd3, 0, 1, 0);   // flips to down in PARADO
        add(1, 2'd0, 0, 0, 2'd2, 0, 0, 0);
        add(4, 2'd0, 0, 0, 2'd2, 0, 1, 0);
        add(1, 2'd0, 0, 0, 2'd1, 0, 0, 0);
        add(4, 2'd0, 0, 0, 2'd1, 0, 1, 0);
        add(2, 2'd0, 0, 0, 2'd0, 0, 0, 0);

        // ---- reset held while inputs toggle ----
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            proximo_andar    = 2'($urandom_range(0, 3));
            andar_solicitado = 1'($urandom_range(0, 1));
            obstrucao_porta  = 1'($urandom_range(0, 1));
            tick();
            chk_outs($sformatf("rst_hold%0d", i), 2'd0, 1'b1, 1'b0, 1'b0);
        end
        proximo_andar = 2'd0; andar_solicitado = 1'b0; obstrucao_porta = 1'b0;
        reset_n = 1'b1;
        tick();
        chk_outs("rst_release", 2'd0, 1'b1, 1'b0, 1'b0);

        // ---- directed table ----
        for (int i = 0; i < tab.size(); i++) begin
            proximo_andar    = tab[i].prox;
            andar_solicitado = tab[i].req;
            obstrucao_porta  = tab[i].obs;
            tick();
            chk_outs($sformatf("vec%0d", i), tab[i].andar, tab[i].dir, tab[i].mov, tab[i].porta);
        end

        // ---- intermediate stop: 0->3, request raised at floor 1 ----
        proximo_andar = 2'd3; andar_solicitado = 1'b0; obstrucao_porta = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_outs("stop.f1", 2'd1, 1'b1, 1'b0, 1'b0);
        andar_solicitado = 1'b1;
        tick();
        chk_outs("stop.open", 2'd1, 1'b1, 1'b0, 1'b1);
        andar_solicitado = 1'b0;
        tick(); tick();
        chk_outs("stop.dwell", 2'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_outs("stop.closed", 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_outs("stop.resume", 2'd1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk_outs("stop.f2", 2'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk_outs("stop.f3", 2'd3, 1'b1, 1'b0, 1'b0);

        // ---- asynchronous reset in the middle of a trip ----
        proximo_andar = 2'd0;
        tick(); tick();
        chk_outs("async.moving", 2'd3, 1'b0, 1'b1, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        chk_outs("async.now", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_outs("async.held", 2'd0, 1'b1, 1'b0, 1'b0);
        proximo_andar = 2'd0;
        reset_n = 1'b1;
        tick();
        chk_outs("async.after", 2'd0, 1'b1, 1'b0, 1'b0);

        // ---- random traffic against the model ----
        model_reset();
        proximo_andar = 2'd0; andar_solicitado = 1'b0; obstrucao_porta = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) proximo_andar = 2'($urandom_range(0, 3));
            andar_solicitado = ($urandom_range(0, 7) == 0);
            obstrucao_porta  = ($urandom_range(0, 3) == 0);
            model_edge(int'(proximo_andar), andar_solicitado, obstrucao_porta);
            tick();
            chk_outs($sformatf("rnd%0d", i), 2'(m_andar), 1'(m_dir),
                     (m_mov_left > 0), (m_porta_left > 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
